// File: rtl/molecular_structure_assembler.sv
// Packs WORD_W-bit atom-record words into one 256-bit molecular_structure frame.
// Define STRUCT_CHECKSUM_EN to require a trailing XOR checksum word on every frame.
module molecular_structure_assembler #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WORD_W-1:0]           word_in,
    input  logic                        word_valid,
    input  logic                        word_last,
    output logic                        word_ready,
    output logic [WORD_W*NUM_WORDS-1:0] molecular_structure,
    output logic                        structure_valid,
    input  logic                        structure_ack,
    output logic                        frame_error,
    output logic [7:0]                  error_count
);

    localparam int FRAME_W = WORD_W * NUM_WORDS;
`ifdef STRUCT_CHECKSUM_EN
    localparam int FRAME_LEN = NUM_WORDS + 1;
`else
    localparam int FRAME_LEN = NUM_WORDS;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_WORDS = CNT_W'(NUM_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD,
        DROP
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   word_cnt;
    logic [FRAME_W-1:0] asm_q;
    logic [FRAME_W-1:0] asm_next;
    logic               accept;
    logic               store;
    logic               publish;
    logic               error;
    logic               cnt_inc;

`ifdef STRUCT_CHECKSUM_EN
    logic [WORD_W-1:0]  xor_acc;
    logic               checksum_ok;

    assign checksum_ok = (word_in == xor_acc);
`endif

    assign word_ready = (state != HOLD);
    assign accept     = word_valid && word_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        store      = 1'b0;
        publish    = 1'b0;
        error      = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                if (accept) begin
                    store = (word_cnt < DATA_WORDS);
                    if (word_cnt == LAST_IDX) begin
                        if (!word_last) begin
                            error      = 1'b1;
                            next_state = DROP;
`ifdef STRUCT_CHECKSUM_EN
                        end else if (!checksum_ok) begin
                            error      = 1'b1;
                            next_state = IDLE;
`endif
                        end else begin
                            publish    = 1'b1;
                            next_state = HOLD;
                        end
                    end else if (word_last) begin
                        error      = 1'b1;
                        next_state = IDLE;
                    end else begin
                        cnt_inc    = 1'b1;
                        next_state = COLLECT;
                    end
                end
            end
            HOLD: begin
                if (structure_ack) begin
                    next_state = IDLE;
                end
            end
            DROP: begin
                if (accept && word_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Publish takes asm_next so the final data word lands in the same edge it is accepted.
    always_comb begin
        asm_next = asm_q;
        for (int unsigned k = 0; k < NUM_WORDS; k++) begin
            if (store && word_cnt == CNT_W'(k)) begin
                asm_next[k*WORD_W +: WORD_W] = word_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            word_cnt            <= '0;
            asm_q               <= '0;
            molecular_structure <= '0;
            structure_valid     <= 1'b0;
            frame_error         <= 1'b0;
            error_count         <= '0;
        end else begin
            asm_q <= asm_next;
            if (cnt_inc) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end else if (next_state != COLLECT) begin
                word_cnt <= '0;
            end
            if (publish) begin
                molecular_structure <= asm_next;
                structure_valid     <= 1'b1;
            end else if (state == HOLD && structure_ack) begin
                structure_valid <= 1'b0;
            end
            frame_error <= error;
            if (error && error_count != 8'hFF) begin
                error_count <= error_count + 8'd1;
            end
        end
    end

`ifdef STRUCT_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            xor_acc <= '0;
        end else if (store) begin
            xor_acc <= (word_cnt == '0) ? word_in : (xor_acc ^ word_in);
        end
    end
`endif

endmodule

// File: tb/tb_molecular_structure_assembler.sv
// Scoreboard bench: random frames against a frame-level model of the assembler.
module tb_molecular_structure_assembler;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 8;
    localparam int FRAME_W   = WORD_W * NUM_WORDS;
`ifdef STRUCT_CHECKSUM_EN
    localparam int FRAME_LEN = NUM_WORDS + 1;
`else
    localparam int FRAME_LEN = NUM_WORDS;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [WORD_W-1:0]  word_in;
    logic               word_valid;
    logic               word_last;
    logic               word_ready;
    logic [FRAME_W-1:0] molecular_structure;
    logic               structure_valid;
    logic               structure_ack;
    logic               frame_error;
    logic [7:0]         error_count;

    always #5 clk = ~clk;

    molecular_structure_assembler #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .word_in             (word_in),
        .word_valid          (word_valid),
        .word_last           (word_last),
        .word_ready          (word_ready),
        .molecular_structure (molecular_structure),
        .structure_valid     (structure_valid),
        .structure_ack       (structure_ack),
        .frame_error         (frame_error),
        .error_count         (error_count)
    );

    typedef struct {
        bit                 is_err;
        logic [FRAME_W-1:0] data;
        int unsigned        cnt;
    } ev_t;

    ev_t                exp_q[$];
    int                 total = 0;
    int                 bad = 0;
    int unsigned        model_errs = 0;
    logic [FRAME_W-1:0] last_pub = '0;
    bit                 in_reset = 1'b1;
    logic               acc_last = 1'b0;

    always @(posedge clk) acc_last <= word_valid && word_ready && word_last && reset;

    task automatic chk(input string name, input logic [FRAME_W-1:0] act, input logic [FRAME_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor and consumer: pops the scoreboard on every publish or error pulse.
    initial begin : monitor
        bit  prev_valid;
        bit  ack_hold;
        ev_t ev;
        prev_valid = 1'b0;
        ack_hold   = 1'b0;
        forever begin
            @(negedge clk);
            if (in_reset) begin
                prev_valid    = 1'b0;
                ack_hold      = 1'b0;
                structure_ack = 1'b0;
            end else begin
                if (ack_hold) begin
                    chk("ack_clears_valid", structure_valid, 0);
                    chk("ready_after_ack", word_ready, 1);
                end
                chk("ready_vs_hold", word_ready, !structure_valid);
                if (structure_valid && !prev_valid) begin
                    chk("publish_latency", acc_last, 1);
                    chk("publish_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        ev = exp_q.pop_front();
                        chk("publish_kind_is_err", ev.is_err, 0);
                        chk("structure_data", molecular_structure, ev.data);
                        if (!ev.is_err) last_pub = ev.data;
                    end
                end
                chk("structure_stable", molecular_structure, last_pub);
                if (frame_error) begin
                    chk("error_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        ev = exp_q.pop_front();
                        chk("error_kind_is_err", ev.is_err, 1);
                        chk("error_count", error_count, ev.cnt);
                    end
                end
                prev_valid    = structure_valid;
                structure_ack = structure_valid ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
                ack_hold      = structure_ack && structure_valid;
            end
        end
    end

    task automatic drive_word(input logic [WORD_W-1:0] w, input bit last);
        bit          done;
        int unsigned waited;
        done   = 1'b0;
        waited = 0;
        while (!done) begin
            @(negedge clk);
            if ($urandom_range(0, 4) == 0) begin
                word_valid = 1'b0;
            end else begin
                word_valid = 1'b1;
                word_in    = w;
                word_last  = last;
                done       = word_ready;
            end
            waited++;
            if (!done && waited > 300) begin
                total++;
                bad++;
                $display("FAIL word_accept_timeout: word_ready=%0b after %0d cycles, required 1", word_ready, waited);
                done = 1'b1;
            end
        end
    endtask

    // kind: 0 random words, 1 counting words 1..n, 2 all-zero words.
    task automatic send_frame(input int unsigned len, input int unsigned kind, input bit bad_ck);
        logic [WORD_W-1:0] w[$];
        logic [WORD_W-1:0] x;
        logic [WORD_W-1:0] v;
        ev_t               ev;
        bit                ok;
        x = '0;
        for (int unsigned i = 0; i < len; i++) begin
            v = (kind == 1) ? WORD_W'(i + 1) : (kind == 2) ? '0 : $urandom;
            w.push_back(v);
            if (i < NUM_WORDS) x = x ^ v;
        end
`ifdef STRUCT_CHECKSUM_EN
        if (len >= FRAME_LEN) w[NUM_WORDS] = x ^ {{(WORD_W-1){1'b0}}, bad_ck};
        ok = (len == FRAME_LEN) && !bad_ck;
`else
        ok = (len == FRAME_LEN) && (bad_ck || !bad_ck) && (x == x);
`endif
        ev.is_err = !ok;
        ev.data   = '0;
        if (ok) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) ev.data[i*WORD_W +: WORD_W] = w[i];
        end else if (model_errs < 255) begin
            model_errs++;
        end
        ev.cnt = model_errs;
        exp_q.push_back(ev);
        foreach (w[i]) drive_word(w[i], i == len - 1);
    endtask

    task automatic do_reset(input int unsigned cycles);
        @(negedge clk);
        in_reset   = 1'b1;
        reset      = 1'b0;
        word_valid = 1'b0;
        word_last  = 1'b0;
        repeat (cycles) @(negedge clk);
        chk("rst_valid", structure_valid, 0);
        chk("rst_frame_error", frame_error, 0);
        chk("rst_error_count", error_count, 0);
        chk("rst_structure", molecular_structure, 0);
        chk("rst_ready", word_ready, 1);
        reset      = 1'b1;
        exp_q.delete();
        model_errs = 0;
        last_pub   = '0;
        in_reset   = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        @(negedge clk);
        word_valid = 1'b0;
        word_last  = 1'b0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin : stim
        int unsigned r;
        word_in       = '0;
        word_valid    = 1'b0;
        word_last     = 1'b0;
        structure_ack = 1'b0;
        do_reset(3);

        send_frame(FRAME_LEN, 1, 1'b0);
        send_frame(3, 0, 1'b0);
        send_frame(FRAME_LEN, 0, 1'b0);
        send_frame(FRAME_LEN + 2, 0, 1'b0);
        send_frame(FRAME_LEN, 2, 1'b0);
`ifdef STRUCT_CHECKSUM_EN
        send_frame(FRAME_LEN, 1, 1'b1);
`endif
        drain();

        for (int unsigned i = 0; i < 5; i++) drive_word($urandom, 1'b0);
        do_reset(2);
        send_frame(FRAME_LEN, 0, 1'b0);

        for (int unsigned f = 0; f < 60; f++) begin
            r = $urandom_range(0, 9);
            if (r < 5) send_frame(FRAME_LEN, (r == 0) ? 2 : 0, ($urandom_range(0, 3) == 0));
            else if (r < 8) send_frame($urandom_range(1, FRAME_LEN - 1), 0, 1'b0);
            else send_frame($urandom_range(FRAME_LEN + 1, FRAME_LEN + 3), 0, 1'b0);
        end
        drain();

        repeat (260) send_frame(1, 0, 1'b0);
        send_frame(FRAME_LEN, 0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
